// File: rtl/reservation_station_if.sv
// Bundle of the dispatch, complete-broadcast and issue signals of the
// reservation station.
//   master : upstream/downstream side (drives dispatch, complete, issue_ready)
//   slave  : the reservation station itself
interface reservation_station_if #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 64,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              disp_valid;
  logic              disp_ready;
  logic [31:0]       disp_instr;
  logic [TAG_W-1:0]  disp_dest_tag;
  logic              disp_src1_valid;
  logic [TAG_W-1:0]  disp_src1;
  logic              disp_src2_valid;
  logic [TAG_W-1:0]  disp_src2;
  logic              complete_en;
  logic [TAG_W-1:0]  complete_tag;
  logic [DATA_W-1:0] complete_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [31:0]       issue_instr;
  logic [TAG_W-1:0]  issue_dest_tag;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;
  logic [CW-1:0]     count;

  modport master (
    output disp_valid, disp_instr, disp_dest_tag, disp_src1_valid, disp_src1,
           disp_src2_valid, disp_src2, complete_en, complete_tag, complete_data,
           issue_ready,
    input  disp_ready, issue_valid, issue_instr, issue_dest_tag, issue_op1,
           issue_op2, count
  );

  modport slave (
    input  disp_valid, disp_instr, disp_dest_tag, disp_src1_valid, disp_src1,
           disp_src2_valid, disp_src2, complete_en, complete_tag, complete_data,
           issue_ready,
    output disp_ready, issue_valid, issue_instr, issue_dest_tag, issue_op1,
           issue_op2, count
  );
endinterface

// File: rtl/reservation_station.sv
// Age-ordered operand-wait buffer (collapsing queue, slot 0 = oldest).
// Captures operands from the complete broadcast and issues the oldest entry
// with both operands ready.
//   clock : system clock
//   reset : synchronous active-high reset (priority over flash)
//   flash : pipeline flush, empties the station
//   rs    : dispatch / complete / issue bundle (slave side)

// Operand wakeup: a not-ready operand whose tag matches the broadcast
// captures the broadcast data. Shared by stored entries and dispatch bypass.
module rs_wake #(
  parameter int TAG_W  = 64,
  parameter int DATA_W = 32
) (
  input  logic              rdy_in,
  input  logic [TAG_W-1:0]  val_in,
  input  logic              complete_en,
  input  logic [TAG_W-1:0]  complete_tag,
  input  logic [DATA_W-1:0] complete_data,
  output logic              rdy_out,
  output logic [TAG_W-1:0]  val_out
);
  logic hit;
  assign hit     = complete_en && !rdy_in && (val_in == complete_tag);
  assign rdy_out = rdy_in | hit;
  assign val_out = hit ? TAG_W'(complete_data) : val_in;
endmodule

module reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 64,
  parameter int DATA_W = 32
) (
  input logic clock,
  input logic reset,
  input logic flash,
  reservation_station_if.slave rs
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] val;   // data (zero-extended) when rdy, else tag
  } opnd_t;

  typedef struct packed {
    logic [31:0]      instr;
    logic [TAG_W-1:0] dest;
    opnd_t            s1;
    opnd_t            s2;
  } entry_t;

  entry_t [DEPTH-1:0] ent, wk, shf, nxt;
  entry_t             dsp;
  logic   [DEPTH-1:0] vld;
  logic   [CW-1:0]    count_q, wr;
  logic   [IW-1:0]    sel;
  logic               sel_hit, fire, disp_fire;

  assign rs.disp_ready = count_q < CW'(DEPTH);
  assign rs.count      = count_q;
  assign disp_fire     = rs.disp_valid && rs.disp_ready;
  assign fire          = sel_hit && rs.issue_ready;
  // A same-cycle issue collapses the queue, so the new entry lands one lower.
  assign wr            = count_q - CW'(fire);

  // Oldest ready entry; scanning downward lets the lowest index win.
  // Uses registered rdy bits only, so a broadcast never issues same cycle.
  always_comb begin
    sel_hit = 1'b0;
    sel     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld[i] && ent[i].s1.rdy && ent[i].s2.rdy) begin
        sel_hit = 1'b1;
        sel     = IW'(i);
      end
    end
  end

  assign rs.issue_valid    = sel_hit;
  assign rs.issue_instr    = sel_hit ? ent[sel].instr : '0;
  assign rs.issue_dest_tag = sel_hit ? ent[sel].dest : '0;
  assign rs.issue_op1      = sel_hit ? ent[sel].s1.val[DATA_W-1:0] : '0;
  assign rs.issue_op2      = sel_hit ? ent[sel].s2.val[DATA_W-1:0] : '0;

  // Incoming entry, with bypass for a broadcast landing during dispatch.
  assign dsp.instr = rs.disp_instr;
  assign dsp.dest  = rs.disp_dest_tag;
  rs_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_dsp1 (
    .rdy_in(rs.disp_src1_valid), .val_in(rs.disp_src1),
    .complete_en(rs.complete_en), .complete_tag(rs.complete_tag),
    .complete_data(rs.complete_data),
    .rdy_out(dsp.s1.rdy), .val_out(dsp.s1.val));
  rs_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_dsp2 (
    .rdy_in(rs.disp_src2_valid), .val_in(rs.disp_src2),
    .complete_en(rs.complete_en), .complete_tag(rs.complete_tag),
    .complete_data(rs.complete_data),
    .rdy_out(dsp.s2.rdy), .val_out(dsp.s2.val));

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign vld[g]      = CW'(g) < count_q;
    assign wk[g].instr = ent[g].instr;
    assign wk[g].dest  = ent[g].dest;

    rs_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_w1 (
      .rdy_in(ent[g].s1.rdy), .val_in(ent[g].s1.val),
      .complete_en(rs.complete_en), .complete_tag(rs.complete_tag),
      .complete_data(rs.complete_data),
      .rdy_out(wk[g].s1.rdy), .val_out(wk[g].s1.val));
    rs_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_w2 (
      .rdy_in(ent[g].s2.rdy), .val_in(ent[g].s2.val),
      .complete_en(rs.complete_en), .complete_tag(rs.complete_tag),
      .complete_data(rs.complete_data),
      .rdy_out(wk[g].s2.rdy), .val_out(wk[g].s2.val));

    // Shift source is the woken neighbour so wakeup survives a collapse.
    if (g < DEPTH - 1) begin : g_shf
      assign shf[g] = wk[g+1];
    end else begin : g_top
      assign shf[g] = wk[g];
    end

    assign nxt[g] = (disp_fire && wr == CW'(g)) ? dsp :
                    (fire && IW'(g) >= sel)     ? shf[g] : wk[g];
  end

  // Slot validity is implied by count, so the payload needs no reset.
  always_ff @(posedge clock) begin
    if (reset || flash) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(disp_fire) - CW'(fire);
      ent     <= nxt;
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flash = 1'b0;

  always #5 clock = ~clock;

  reservation_station_if #(.DEPTH(4), .TAG_W(64), .DATA_W(32)) rs ();

  reservation_station #(.DEPTH(4), .TAG_W(64), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .flash(flash), .rs(rs));

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] dest;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted issue must match the oldest pending expectation.
  always @(negedge clock) begin
    if (!reset && !flash && rs.issue_valid && rs.issue_ready) begin
      exp_t obs, exp;
      obs = {rs.issue_instr, rs.issue_dest_tag, rs.issue_op1, rs.issue_op2};
      nchk++;
      if (q.size() == 0) begin
        nfail++;
        $error("FAIL issue_unexpected observed=%0h expected=none", obs);
      end else begin
        exp = q.pop_front();
        assert (obs === exp) else begin
          nfail++;
          $error("FAIL issue_payload observed=%0h expected=%0h", obs, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] d,
                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = {i, d, a, b};
    q.push_back(e);
  endtask

  task automatic set_disp(input logic [31:0] i, input logic [63:0] d,
                          input logic v1, input logic [63:0] s1,
                          input logic v2, input logic [63:0] s2);
    rs.disp_valid      = 1'b1;
    rs.disp_instr      = i;
    rs.disp_dest_tag   = d;
    rs.disp_src1_valid = v1;
    rs.disp_src1       = s1;
    rs.disp_src2_valid = v2;
    rs.disp_src2       = s2;
  endtask

  task automatic set_cmp(input logic en, input logic [63:0] t, input logic [31:0] d);
    rs.complete_en   = en;
    rs.complete_tag  = t;
    rs.complete_data = d;
  endtask

  initial begin
    rs.disp_valid = 1'b0; rs.disp_instr = '0; rs.disp_dest_tag = '0;
    rs.disp_src1_valid = 1'b0; rs.disp_src1 = '0;
    rs.disp_src2_valid = 1'b0; rs.disp_src2 = '0;
    rs.issue_ready = 1'b0;
    set_cmp(1'b0, 64'h0, 32'h0);

    // reset state
    tick(); tick();
    chk("rst_count", rs.count, 0);
    chk("rst_disp_ready", rs.disp_ready, 1);
    chk("rst_issue_valid", rs.issue_valid, 0);
    chk("rst_op1", rs.issue_op1, 0);
    reset = 1'b0;

    // ready operands issue next cycle
    set_disp(32'h80010203, 64'h1, 1'b1, 64'd5, 1'b1, 64'd7);
    rs.issue_ready = 1'b1;
    push(32'h80010203, 64'h1, 32'd5, 32'd7);
    tick();
    rs.disp_valid = 1'b0;
    chk("t1_valid", rs.issue_valid, 1);
    chk("t1_count", rs.count, 1);
    tick();
    chk("t1_count_after", rs.count, 0);
    chk("t1_valid_after", rs.issue_valid, 0);

    // wakeup from broadcast, no same-cycle bypass to issue
    set_disp(32'h2, 64'h2, 1'b0, 64'h10, 1'b1, 64'd3);
    tick();
    rs.disp_valid = 1'b0;
    chk("t2_wait", rs.issue_valid, 0);
    tick();
    set_cmp(1'b1, 64'h10, 32'hDEADBEEF);
    push(32'h2, 64'h2, 32'hDEADBEEF, 32'd3);
    #1;
    chk("t2_no_bypass", rs.issue_valid, 0);
    tick();
    set_cmp(1'b0, 64'h0, 32'h0);
    chk("t2_woken", rs.issue_valid, 1);
    chk("t2_op1", rs.issue_op1, 32'hDEADBEEF);
    tick();
    chk("t2_count", rs.count, 0);

    // dispatch-time bypass
    set_disp(32'h3, 64'h3, 1'b1, 64'd4, 1'b0, 64'h22);
    set_cmp(1'b1, 64'h22, 32'd9);
    push(32'h3, 64'h3, 32'd4, 32'd9);
    tick();
    rs.disp_valid = 1'b0;
    set_cmp(1'b0, 64'h0, 32'h0);
    chk("t3_valid", rs.issue_valid, 1);
    chk("t3_op2", rs.issue_op2, 9);
    tick();

    // both operands share one tag
    set_disp(32'h4, 64'h4, 1'b0, 64'h60, 1'b0, 64'h60);
    tick();
    rs.disp_valid = 1'b0;
    set_cmp(1'b1, 64'h60, 32'h77);
    push(32'h4, 64'h4, 32'h77, 32'h77);
    tick();
    set_cmp(1'b0, 64'h0, 32'h0);
    chk("t4_valid", rs.issue_valid, 1);
    tick();

    // fill: oldest waits, younger ready ones bypass it
    rs.issue_ready = 1'b0;
    set_disp(32'hA, 64'hA, 1'b0, 64'h30, 1'b1, 64'd1);
    tick();
    set_disp(32'hB, 64'hB, 1'b1, 64'hB1, 1'b1, 64'hB2); push(32'hB, 64'hB, 32'hB1, 32'hB2);
    tick();
    set_disp(32'hC, 64'hC, 1'b1, 64'hC1, 1'b1, 64'hC2); push(32'hC, 64'hC, 32'hC1, 32'hC2);
    tick();
    set_disp(32'hD, 64'hD, 1'b1, 64'hD1, 1'b1, 64'hD2); push(32'hD, 64'hD, 32'hD1, 32'hD2);
    tick();
    chk("full_count", rs.count, 4);
    chk("full_disp_ready", rs.disp_ready, 0);
    chk("full_sel", rs.issue_dest_tag, 64'hB);
    set_disp(32'hE, 64'hE, 1'b1, 64'hE1, 1'b1, 64'hE2);
    tick();
    rs.disp_valid = 1'b0;
    chk("full_ignored", rs.count, 4);
    rs.issue_ready = 1'b1;
    tick();
    chk("drain1_count", rs.count, 3);
    chk("drain1_ready", rs.disp_ready, 1);
    chk("drain1_sel", rs.issue_dest_tag, 64'hC);
    tick();
    chk("drain2_sel", rs.issue_dest_tag, 64'hD);
    tick();
    chk("drain3_count", rs.count, 1);
    chk("drain3_valid", rs.issue_valid, 0);

    // simultaneous issue and dispatch at count=2
    rs.issue_ready = 1'b0;
    set_disp(32'hF, 64'hF, 1'b1, 64'hF1, 1'b1, 64'hF2); push(32'hF, 64'hF, 32'hF1, 32'hF2);
    tick();
    chk("sim_pre_count", rs.count, 2);
    set_disp(32'h6, 64'h6, 1'b0, 64'h40, 1'b1, 64'd4);
    rs.issue_ready = 1'b1;
    tick();
    rs.disp_valid = 1'b0;
    chk("sim_count", rs.count, 2);
    chk("sim_valid", rs.issue_valid, 0);
    set_cmp(1'b1, 64'h40, 32'h66);
    push(32'h6, 64'h6, 32'h66, 32'd4);
    tick();
    set_cmp(1'b0, 64'h0, 32'h0);
    chk("slot1_sel", rs.issue_dest_tag, 64'h6);
    tick();
    chk("slot1_count", rs.count, 1);
    set_cmp(1'b1, 64'h30, 32'h55);
    push(32'hA, 64'hA, 32'h55, 32'd1);
    tick();
    set_cmp(1'b0, 64'h0, 32'h0);
    chk("old_sel", rs.issue_dest_tag, 64'hA);
    tick();
    chk("old_count", rs.count, 0);

    // flash with pending entries, dispatch and broadcast all ignored
    rs.issue_ready = 1'b0;
    set_disp(32'h50, 64'h50, 1'b0, 64'h50, 1'b1, 64'd0); tick();
    set_disp(32'h51, 64'h51, 1'b0, 64'h51, 1'b1, 64'd0); tick();
    set_disp(32'h52, 64'h52, 1'b0, 64'h52, 1'b1, 64'd0); tick();
    chk("fl_pre_count", rs.count, 3);
    flash = 1'b1;
    set_disp(32'h53, 64'h53, 1'b1, 64'd1, 1'b1, 64'd2);
    set_cmp(1'b1, 64'h50, 32'h1);
    rs.issue_ready = 1'b1;
    tick();
    flash = 1'b0;
    rs.disp_valid = 1'b0;
    chk("fl_count", rs.count, 0);
    chk("fl_valid", rs.issue_valid, 0);
    chk("fl_disp_ready", rs.disp_ready, 1);
    chk("fl_op1", rs.issue_op1, 0);
    set_cmp(1'b1, 64'h51, 32'h2);
    tick();
    set_cmp(1'b0, 64'h0, 32'h0);
    chk("fl_revive_count", rs.count, 0);
    chk("fl_revive_valid", rs.issue_valid, 0);
    tick();

    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
